prog_clock_divider: RTL and testbench

Parametrised, run-time programmable clock divider. It generates a glitch-free divided clock output and a one-cycle tick from the system clock. A new period is loaded through a valid/ready handshake and is applied only at a period boundary, so the output never produces a runt pulse. It sits between the configuration logic and any block that needs a slow clock-enable or an external divided clock.

---
 rtl/prog_clock_divider.sv | 96 +++++++++
 tb/tb_prog_clock_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: registered divided clock plus a one-cycle tick per period; DIV_DUTY_EN adds cfg_high.
// Latency: outputs lag the counter by one cycle; a new period applies at the next wrap, or on the next edge when idle.
// Backpressure: cfg_ready drops while a period is pending and rises again the cycle after it is applied.
module prog_clock_divider #(
    parameter int CNT_W          = 26,
    parameter int DEFAULT_PERIOD = 60000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
`ifdef DIV_DUTY_EN
    input  logic [CNT_W-1:0] cfg_high,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] period_q
);

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_P  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DEF_HI = DEF_P >> 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] shadow_high;
    logic [CNT_W-1:0] req_period;
    logic [CNT_W-1:0] req_high;
    logic             pending;
    logic             xfer;
    logic             last;
    logic             apply;

    // Clamp at capture time so the apply edge only has to copy registers.
    always_comb begin
        req_period = (cfg_period < MIN_P) ? MIN_P : cfg_period;
`ifdef DIV_DUTY_EN
        req_high = cfg_high;
        if (cfg_high < ONE)
            req_high = ONE;
        else if (cfg_high > req_period - ONE)
            req_high = req_period - ONE;
`else
        req_high = req_period >> 1;
`endif
    end

    assign last      = (cnt == period_q - ONE);
    assign xfer      = cfg_valid & ~pending;
    assign apply     = pending & (~en | last);
    assign cfg_ready = ~pending;

    // Counter and outputs always use the period/high count active before this edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            cnt     <= last ? '0 : cnt + ONE;
            clk_out <= (cnt < hi_q);
            tick    <= last;
        end else begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end
    end

    // A transfer can never coincide with an apply: ready is low whenever pending is set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_q      <= DEF_P;
            hi_q          <= DEF_HI;
            pending       <= 1'b0;
            shadow_period <= DEF_P;
            shadow_high   <= DEF_HI;
        end else begin
            if (apply) begin
                period_q <= shadow_period;
                hi_q     <= shadow_high;
                pending  <= 1'b0;
            end
            if (xfer) begin
                shadow_period <= req_period;
                shadow_high   <= req_high;
                pending       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;

    localparam int W   = 8;
    localparam int DEF = 6;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_high = '0;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] period_q;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of (clk_out,tick) pairs for the rest of the current period.
    int m_p, m_hi, m_pend_p, m_pend_hi;
    bit m_pend, m_clk, m_tick, last_xfer;
    int q[$];

    prog_clock_divider #(.CNT_W(W), .DEFAULT_PERIOD(DEF)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
`ifdef DIV_DUTY_EN
        .cfg_high   (cfg_high),
`endif
        .clk_out    (clk_out),
        .tick       (tick),
        .period_q   (period_q)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_p = DEF; m_hi = DEF / 2; m_pend = 0; m_clk = 0; m_tick = 0;
        m_pend_p = DEF; m_pend_hi = DEF / 2;
        q.delete();
    endtask

    task automatic gen_period();
        repeat (m_hi) q.push_back(2);
        repeat (m_p - m_hi - 1) q.push_back(0);
        q.push_back(1);
    endtask

    task automatic model_step(output bit did_xfer);
        bit pb;
        bit wrap;
        int item;
        int p;
        int h;
        pb = m_pend;
        wrap = 0;
        if (en) begin
            if (q.size() == 0) gen_period();
            item = q.pop_front();
            m_clk = item[1];
            m_tick = item[0];
            wrap = (q.size() == 0);
        end else begin
            q.delete();
            m_clk = 0;
            m_tick = 0;
        end
        if (pb && (wrap || !en)) begin
            m_p = m_pend_p; m_hi = m_pend_hi; m_pend = 0;
        end
        did_xfer = cfg_valid && !pb;
        if (did_xfer) begin
            p = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
`ifdef DIV_DUTY_EN
            h = int'(cfg_high);
            if (h < 1) h = 1;
            else if (h > p - 1) h = p - 1;
`else
            h = p / 2;
`endif
            m_pend = 1; m_pend_p = p; m_pend_hi = h;
        end
    endtask

    task automatic cyc();
        bit x;
        @(posedge clock);
        model_step(x);
        last_xfer = x;
        #1;
        chk("clk_out", int'(clk_out), int'(m_clk));
        chk("tick", int'(tick), int'(m_tick));
        chk("period_q", int'(period_q), m_p);
        chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load(input int p, input int h);
        bit got;
        cfg_valid = 1'b1;
        cfg_period = W'(p);
        cfg_high = W'(h);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            cyc();
            got = last_xfer;
        end
        cfg_valid = 1'b0;
        n_tests++;
        assert (got) else begin
            n_fail++;
            $error("FAIL load_timeout: observed no transfer expected transfer of %0d", p);
        end
    endtask

    initial begin
        m_reset();
        #12;
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_period_q", int'(period_q), DEF);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        @(negedge clock);
        reset = 1'b1;
        #1;

        en = 1'b1;
        run(8);
        load(4, 2);
        run(14);
        chk("p4_period_q", int'(period_q), 4);

        load(5, 2);
        run(16);
        chk("p5_period_q", int'(period_q), 5);

        load(1, 0);
        run(8);
        chk("p1_clamp", int'(period_q), 2);
        load(0, 0);
        run(8);
        chk("p0_clamp", int'(period_q), 2);

        // Second request is offered while the first is still pending.
        load(8, 4);
        run(10);
        load(4, 2);
        load(3, 1);
        run(20);

        load(6, 3);
        run(9);
        en = 1'b0;
        cyc();
        chk("idle_clk_out", int'(clk_out), 0);
        load(7, 3);
        cyc();
        chk("idle_apply", int'(period_q), 7);
        en = 1'b1;
        run(16);

        // Async reset with an update still pending.
        load(9, 4);
        load(5, 2);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        chk("arst_clk_out", int'(clk_out), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_period_q", int'(period_q), DEF);
        chk("arst_cfg_ready", int'(cfg_ready), 1);
        #2;
        reset = 1'b1;
        run(14);

`ifdef DIV_DUTY_EN
        load(10, 3);
        run(22);
        load(10, 0);
        run(22);
`endif

        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_period = W'($urandom_range(0, 12));
            cfg_high = W'($urandom_range(0, 12));
            cyc();
        end
        cfg_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
